// File: rtl/axi4_sub_mem_pkg.sv
// Shared types and constants for the AXI4 subordinate memory.
package axi4_sub_mem_pkg;

  typedef enum logic [1:0] {
    FIXED = 2'b00,
    INCR  = 2'b01,
    WRAP  = 2'b10,
    RSVD  = 2'b11
  } burst_e;

  localparam logic [1:0] OKAY   = 2'b00;
  localparam logic [1:0] SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_e;
  typedef enum logic {R_IDLE, R_DATA} rd_state_e;

  localparam logic [15:0] LFSR_SEED = 16'hACE1;

  // x^16 + x^14 + x^13 + x^11 Fibonacci step
  function automatic logic [15:0] lfsr_next(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction

endpackage

// File: rtl/axi4_bus_if.sv
// AXI4 bus (AW/W/B/AR/R) shared by axi4_mgr and axi4_sub_mem.
interface axi4_bus_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 64,
  parameter int ID_W   = 9,
  parameter int USER_W = 5
);
  logic [ID_W-1:0]     aw_id;
  logic [ADDR_W-1:0]   aw_addr;
  logic [7:0]          aw_len;
  logic [2:0]          aw_size;
  logic [1:0]          aw_burst;
  logic [USER_W-1:0]   aw_user;
  logic                aw_valid;
  logic                aw_ready;

  logic [DATA_W-1:0]   w_data;
  logic [DATA_W/8-1:0] w_strb;
  logic                w_last;
  logic [USER_W-1:0]   w_user;
  logic                w_valid;
  logic                w_ready;

  logic [ID_W-1:0]     b_id;
  logic [1:0]          b_resp;
  logic [USER_W-1:0]   b_user;
  logic                b_valid;
  logic                b_ready;

  logic [ID_W-1:0]     ar_id;
  logic [ADDR_W-1:0]   ar_addr;
  logic [7:0]          ar_len;
  logic [2:0]          ar_size;
  logic [1:0]          ar_burst;
  logic [USER_W-1:0]   ar_user;
  logic                ar_valid;
  logic                ar_ready;

  logic [ID_W-1:0]     r_id;
  logic [DATA_W-1:0]   r_data;
  logic [1:0]          r_resp;
  logic                r_last;
  logic [USER_W-1:0]   r_user;
  logic                r_valid;
  logic                r_ready;

  modport Manager (
    output aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid, input aw_ready,
    output w_data, w_strb, w_last, w_user, w_valid, input w_ready,
    input  b_id, b_resp, b_user, b_valid, output b_ready,
    output ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid, input ar_ready,
    input  r_id, r_data, r_resp, r_last, r_user, r_valid, output r_ready
  );

  modport Subordinate (
    input  aw_id, aw_addr, aw_len, aw_size, aw_burst, aw_user, aw_valid, output aw_ready,
    input  w_data, w_strb, w_last, w_user, w_valid, output w_ready,
    output b_id, b_resp, b_user, b_valid, input b_ready,
    input  ar_id, ar_addr, ar_len, ar_size, ar_burst, ar_user, ar_valid, output ar_ready,
    output r_id, r_data, r_resp, r_last, r_user, r_valid, input r_ready
  );
endinterface

// File: rtl/axi4_burst_addr_gen.sv
// Next beat address, word index and legality for one burst beat.
module axi4_burst_addr_gen
  import axi4_sub_mem_pkg::*;
#(
  parameter int              ADDR_W    = 32,
  parameter int              DATA_W    = 64,
  parameter longint unsigned MEM_BASE  = 'h5000,
  parameter int              MEM_WORDS = 1024
) (
  input  logic [ADDR_W-1:0]            addr,
  input  logic [7:0]                   len,
  input  logic [2:0]                   size,
  input  logic [1:0]                   burst,
  output logic [ADDR_W-1:0]            next_addr,
  output logic [$clog2(MEM_WORDS)-1:0] word_idx,
  output logic                         err
);
  localparam int                IDX_W      = $clog2(MEM_WORDS);
  localparam int                LOG2_BYTES = $clog2(DATA_W / 8);
  localparam logic [ADDR_W-1:0] BASE       = ADDR_W'(MEM_BASE);

  logic [ADDR_W-1:0] step;
  logic [ADDR_W-1:0] incr_addr;
  logic [ADDR_W-1:0] wrap_mask;
  logic [ADDR_W-1:0] offset_words;
  logic              burst_err;
  logic              range_err;

  // Address arithmetic and legality of the current beat
  always_comb begin
    step         = ADDR_W'(1) << size;
    incr_addr    = addr + step;
    wrap_mask    = ((ADDR_W'(len) + ADDR_W'(1)) << size) - ADDR_W'(1);
    offset_words = (addr - BASE) >> LOG2_BYTES;
    word_idx     = offset_words[IDX_W-1:0];
    next_addr    = addr;
    case (burst)
      INCR:    next_addr = incr_addr;
      WRAP:    next_addr = (addr & ~wrap_mask) | (incr_addr & wrap_mask);
      default: next_addr = addr;
    endcase
    burst_err = (burst == RSVD)
             || ((burst == WRAP) && !(len inside {8'd1, 8'd3, 8'd7, 8'd15}))
             || (size > 3'(LOG2_BYTES));
    // BASE is word aligned, so a word-offset compare is equivalent to the byte range
    range_err = (addr < BASE) || (offset_words >= ADDR_W'(MEM_WORDS));
    err       = burst_err | range_err;
  end

endmodule

// File: rtl/axi4_sub_mem.sv
// AXI4 subordinate scratch RAM with independent write and read channels.
// Optional random backpressure: define AXI4_SUB_MEM_STALL_EN.
//
// state  | meaning
// W_IDLE | waiting for AW, aw_ready high
// W_DATA | accepting W beats, w_ready high (unless stalled)
// W_RESP | presenting B until b_ready
// R_IDLE | waiting for AR, ar_ready high
// R_DATA | presenting R beats, next beat prefetched on each handshake
module axi4_sub_mem
  import axi4_sub_mem_pkg::*;
#(
  parameter int              AXI_ADDR_WIDTH = 32,
  parameter int              AXI_DATA_WIDTH = 64,
  parameter int              AXI_ID_WIDTH   = 9,
  parameter int              AXI_USER_WIDTH = 5,
  parameter longint unsigned MEM_BASE       = 'h5000,
  parameter int              MEM_WORDS      = 1024
) (
  input  logic              clk_i,
  input  logic              rst_i,
  axi4_bus_if.Subordinate   axi_sub_if,
  output logic [31:0]       wr_beats_o,
  output logic [31:0]       rd_beats_o
);
  localparam int BYTES = AXI_DATA_WIDTH / 8;
  localparam int IDX_W = $clog2(MEM_WORDS);

  logic [AXI_DATA_WIDTH-1:0] mem [MEM_WORDS];
  logic                      stall;

`ifdef AXI4_SUB_MEM_STALL_EN
  logic [15:0] lfsr_q;

  // Free-running stall pattern from reset release
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) lfsr_q <= LFSR_SEED;
    else       lfsr_q <= lfsr_next(lfsr_q);
  end
  assign stall = (lfsr_q[1:0] == 2'b00);
`else
  assign stall = 1'b0;
`endif

  // ---------------- write channel ----------------
  wr_state_e                 wr_state_q, wr_state_d;
  logic [AXI_ID_WIDTH-1:0]   wr_id_q;
  logic [AXI_ADDR_WIDTH-1:0] wr_addr_q, wr_next_addr;
  logic [7:0]                wr_len_q;
  logic [2:0]                wr_size_q;
  logic [1:0]                wr_burst_q;
  logic                      wr_err_q;
  logic [8:0]                wr_cnt_q;
  logic [IDX_W-1:0]          wr_idx;
  logic                      wr_beat_err;
  logic                      aw_ready_c, w_ready_c, b_valid_c;
  logic                      aw_hs, w_hs, wr_in_len, mem_we;

  axi4_burst_addr_gen #(
    .ADDR_W(AXI_ADDR_WIDTH), .DATA_W(AXI_DATA_WIDTH),
    .MEM_BASE(MEM_BASE), .MEM_WORDS(MEM_WORDS)
  ) u_wr_gen (
    .addr(wr_addr_q), .len(wr_len_q), .size(wr_size_q), .burst(wr_burst_q),
    .next_addr(wr_next_addr), .word_idx(wr_idx), .err(wr_beat_err)
  );

  assign aw_hs     = axi_sub_if.aw_valid & aw_ready_c;
  assign w_hs      = axi_sub_if.w_valid & w_ready_c;
  assign wr_in_len = (wr_cnt_q <= {1'b0, wr_len_q});
  assign mem_we    = w_hs & wr_in_len & ~wr_beat_err;

  // Write FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) wr_state_q <= W_IDLE;
    else       wr_state_q <= wr_state_d;
  end

  // Write FSM next state and handshake outputs
  always_comb begin
    wr_state_d = wr_state_q;
    aw_ready_c = 1'b0;
    w_ready_c  = 1'b0;
    b_valid_c  = 1'b0;
    case (wr_state_q)
      W_IDLE: begin
        aw_ready_c = ~rst_i;
        if (axi_sub_if.aw_valid && aw_ready_c) wr_state_d = W_DATA;
      end
      W_DATA: begin
        w_ready_c = ~stall;
        if (w_hs && axi_sub_if.w_last) wr_state_d = W_RESP;
      end
      W_RESP: begin
        b_valid_c = 1'b1;
        if (axi_sub_if.b_ready) wr_state_d = W_IDLE;
      end
      default: wr_state_d = W_IDLE;
    endcase
  end

  // Write burst bookkeeping; error is sticky for the whole burst
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_id_q    <= '0;
      wr_addr_q  <= '0;
      wr_len_q   <= '0;
      wr_size_q  <= '0;
      wr_burst_q <= '0;
      wr_err_q   <= 1'b0;
      wr_cnt_q   <= '0;
    end else if (aw_hs) begin
      wr_id_q    <= axi_sub_if.aw_id;
      wr_addr_q  <= axi_sub_if.aw_addr;
      wr_len_q   <= axi_sub_if.aw_len;
      wr_size_q  <= axi_sub_if.aw_size;
      wr_burst_q <= axi_sub_if.aw_burst;
      wr_err_q   <= 1'b0;
      wr_cnt_q   <= '0;
    end else if (w_hs) begin
      wr_addr_q <= wr_next_addr;
      if (wr_in_len) wr_cnt_q <= wr_cnt_q + 9'd1;
      if (wr_beat_err) wr_err_q <= 1'b1;
      if (axi_sub_if.w_last && (wr_cnt_q < {1'b0, wr_len_q})) wr_err_q <= 1'b1;
      if (!axi_sub_if.w_last && (wr_cnt_q >= {1'b0, wr_len_q})) wr_err_q <= 1'b1;
    end
  end

  // Byte-strobed RAM write; contents intentionally survive reset
  always_ff @(posedge clk_i) begin
    if (mem_we) begin
      for (int b = 0; b < BYTES; b++) begin
        if (axi_sub_if.w_strb[b]) mem[wr_idx][8*b +: 8] <= axi_sub_if.w_data[8*b +: 8];
      end
    end
  end

  assign axi_sub_if.aw_ready = aw_ready_c;
  assign axi_sub_if.w_ready  = w_ready_c;
  assign axi_sub_if.b_valid  = b_valid_c;
  assign axi_sub_if.b_id     = wr_id_q;
  assign axi_sub_if.b_resp   = wr_err_q ? SLVERR : OKAY;
  assign axi_sub_if.b_user   = '0;

  // ---------------- read channel ----------------
  rd_state_e                 rd_state_q, rd_state_d;
  logic [AXI_ID_WIDTH-1:0]   rd_id_q;
  logic [AXI_ADDR_WIDTH-1:0] rd_addr_q, rgen_addr, rgen_next;
  logic [7:0]                rd_len_q, rgen_len, rd_beat_q;
  logic [2:0]                rd_size_q, rgen_size;
  logic [1:0]                rd_burst_q, rgen_burst, r_resp_q;
  logic [IDX_W-1:0]          rgen_idx;
  logic                      rgen_err;
  logic [AXI_DATA_WIDTH-1:0] r_data_q;
  logic                      r_valid_q, r_last_q;
  logic                      ar_ready_c, ar_hs, r_hs, fetch;

  // In idle the generator looks at the incoming AR so beat 0 is fetched on the handshake;
  // afterwards rd_addr_q already holds the address of the next beat to fetch.
  assign rgen_addr  = (rd_state_q == R_IDLE) ? axi_sub_if.ar_addr  : rd_addr_q;
  assign rgen_len   = (rd_state_q == R_IDLE) ? axi_sub_if.ar_len   : rd_len_q;
  assign rgen_size  = (rd_state_q == R_IDLE) ? axi_sub_if.ar_size  : rd_size_q;
  assign rgen_burst = (rd_state_q == R_IDLE) ? axi_sub_if.ar_burst : rd_burst_q;

  axi4_burst_addr_gen #(
    .ADDR_W(AXI_ADDR_WIDTH), .DATA_W(AXI_DATA_WIDTH),
    .MEM_BASE(MEM_BASE), .MEM_WORDS(MEM_WORDS)
  ) u_rd_gen (
    .addr(rgen_addr), .len(rgen_len), .size(rgen_size), .burst(rgen_burst),
    .next_addr(rgen_next), .word_idx(rgen_idx), .err(rgen_err)
  );

  assign ar_hs = axi_sub_if.ar_valid & ar_ready_c;
  assign r_hs  = r_valid_q & axi_sub_if.r_ready;
  assign fetch = ar_hs | (r_hs & ~r_last_q);

  // Read FSM state register
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) rd_state_q <= R_IDLE;
    else       rd_state_q <= rd_state_d;
  end

  // Read FSM next state and AR handshake
  always_comb begin
    rd_state_d = rd_state_q;
    ar_ready_c = 1'b0;
    case (rd_state_q)
      R_IDLE: begin
        ar_ready_c = ~rst_i;
        if (axi_sub_if.ar_valid && ar_ready_c) rd_state_d = R_DATA;
      end
      R_DATA: begin
        if (r_hs && r_last_q) rd_state_d = R_IDLE;
      end
      default: rd_state_d = R_IDLE;
    endcase
  end

  // Read datapath: registered RAM read gives old data on a same-cycle write
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      rd_id_q    <= '0;
      rd_addr_q  <= '0;
      rd_len_q   <= '0;
      rd_size_q  <= '0;
      rd_burst_q <= '0;
      rd_beat_q  <= '0;
      r_data_q   <= '0;
      r_resp_q   <= OKAY;
      r_last_q   <= 1'b0;
      r_valid_q  <= 1'b0;
    end else begin
      if (ar_hs) begin
        rd_id_q    <= axi_sub_if.ar_id;
        rd_len_q   <= axi_sub_if.ar_len;
        rd_size_q  <= axi_sub_if.ar_size;
        rd_burst_q <= axi_sub_if.ar_burst;
        rd_beat_q  <= '0;
      end else if (r_hs && !r_last_q) begin
        rd_beat_q <= rd_beat_q + 8'd1;
      end
      if (fetch) begin
        rd_addr_q <= rgen_next;
        r_data_q  <= rgen_err ? '0 : mem[rgen_idx];
        r_resp_q  <= rgen_err ? SLVERR : OKAY;
        r_last_q  <= ar_hs ? (axi_sub_if.ar_len == 8'd0) : (rd_beat_q + 8'd1 == rd_len_q);
        r_valid_q <= ~stall;
      end else if (r_hs) begin
        r_valid_q <= 1'b0;
        r_last_q  <= 1'b0;
      end else if ((rd_state_q == R_DATA) && !r_valid_q && !stall) begin
        r_valid_q <= 1'b1;
      end
    end
  end

  assign axi_sub_if.ar_ready = ar_ready_c;
  assign axi_sub_if.r_valid  = r_valid_q;
  assign axi_sub_if.r_data   = r_data_q;
  assign axi_sub_if.r_resp   = r_resp_q;
  assign axi_sub_if.r_last   = r_last_q;
  assign axi_sub_if.r_id     = rd_id_q;
  assign axi_sub_if.r_user   = '0;

  // Beat counters, wrapping naturally at 2^32
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_beats_o <= '0;
      rd_beats_o <= '0;
    end else begin
      if (w_hs) wr_beats_o <= wr_beats_o + 32'd1;
      if (r_hs) rd_beats_o <= rd_beats_o + 32'd1;
    end
  end

  logic unused_user;
  assign unused_user = ^{axi_sub_if.aw_user, axi_sub_if.w_user, axi_sub_if.ar_user};

endmodule

// File: tb/tb_axi4_sub_mem.sv
// Directed self-checking bench for axi4_sub_mem.
module tb_axi4_sub_mem;
  import axi4_sub_mem_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  axi4_bus_if #(.ADDR_W(32), .DATA_W(64), .ID_W(9), .USER_W(5)) bus ();
  logic [31:0] wr_beats, rd_beats;

  axi4_sub_mem #(
    .AXI_ADDR_WIDTH(32), .AXI_DATA_WIDTH(64), .AXI_ID_WIDTH(9), .AXI_USER_WIDTH(5),
    .MEM_BASE('h5000), .MEM_WORDS(1024)
  ) dut (
    .clk_i(clk), .rst_i(rst), .axi_sub_if(bus), .wr_beats_o(wr_beats), .rd_beats_o(rd_beats)
  );

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] wdata [16];
  logic [7:0]  wstrb [16];
  logic [63:0] rdata [16];
  logic [1:0]  rresp [16];
  logic        rlast [16];
  logic [8:0]  rid;
  int          rcount;
  logic [1:0]  bresp;
  logic [8:0]  bid;

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic send_aw(input logic [8:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit done = 0;
    bus.aw_id = id; bus.aw_addr = addr; bus.aw_len = len; bus.aw_size = size; bus.aw_burst = burst;
    bus.aw_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      done = bus.aw_ready;
      tick();
    end
    bus.aw_valid = 1'b0;
    if (!done) begin n_tests++; n_fail++; $display("FAIL aw_timeout: aw_ready never seen"); end
  endtask

  task automatic send_w(input int n);
    for (int b = 0; b < n; b++) begin
      bit done = 0;
      bus.w_data = wdata[b]; bus.w_strb = wstrb[b]; bus.w_last = (b == n - 1);
      bus.w_valid = 1'b1;
      for (int i = 0; i < 100 && !done; i++) begin
        done = bus.w_ready;
        tick();
      end
      if (!done) begin n_tests++; n_fail++; $display("FAIL w_timeout: beat %0d not accepted", b); end
    end
    bus.w_valid = 1'b0;
    bus.w_last  = 1'b0;
  endtask

  task automatic get_b(input int hold);
    bit done = 0;
    bus.b_ready = 1'b0;
    repeat (hold) tick();
    bus.b_ready = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      done = bus.b_valid;
      if (done) begin bresp = bus.b_resp; bid = bus.b_id; end
      tick();
    end
    bus.b_ready = 1'b0;
    if (!done) begin n_tests++; n_fail++; $display("FAIL b_timeout: b_valid never seen"); end
  endtask

  task automatic send_ar(input logic [8:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [2:0] size, input logic [1:0] burst);
    bit done = 0;
    bus.ar_id = id; bus.ar_addr = addr; bus.ar_len = len; bus.ar_size = size; bus.ar_burst = burst;
    bus.ar_valid = 1'b1;
    for (int i = 0; i < 100 && !done; i++) begin
      done = bus.ar_ready;
      tick();
    end
    bus.ar_valid = 1'b0;
    if (!done) begin n_tests++; n_fail++; $display("FAIL ar_timeout: ar_ready never seen"); end
  endtask

  task automatic get_r(input int max);
    bit last = 0;
    rcount = 0;
    bus.r_ready = 1'b1;
    for (int i = 0; i < 200 && !last && rcount < max; i++) begin
      if (bus.r_valid) begin
        rdata[rcount] = bus.r_data; rresp[rcount] = bus.r_resp;
        rlast[rcount] = bus.r_last; rid = bus.r_id;
        last = bus.r_last;
        rcount++;
      end
      tick();
    end
    bus.r_ready = 1'b0;
    if (rcount != max) begin n_tests++; n_fail++; $display("FAIL r_count: got %0d beats, expected %0d", rcount, max); end
  endtask

  task automatic test_reset();
    repeat (3) tick();
    n_tests++; if (bus.aw_ready !== 1'b0) begin n_fail++; $display("FAIL rst_aw_ready: got %b expected 0", bus.aw_ready); end
    n_tests++; if (bus.ar_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ar_ready: got %b expected 0", bus.ar_ready); end
    n_tests++; if ({bus.b_valid, bus.r_valid, bus.r_last} !== 3'b000) begin n_fail++; $display("FAIL rst_valids: got %b expected 000", {bus.b_valid, bus.r_valid, bus.r_last}); end
    n_tests++; if (bus.r_data !== 64'h0) begin n_fail++; $display("FAIL rst_r_data: got %h expected 0", bus.r_data); end
    n_tests++; if ({bus.r_resp, bus.b_resp, bus.r_id, bus.b_id} !== 22'h0) begin n_fail++; $display("FAIL rst_resp_id: got %h expected 0", {bus.r_resp, bus.b_resp, bus.r_id, bus.b_id}); end
    n_tests++; if ({wr_beats, rd_beats} !== 64'h0) begin n_fail++; $display("FAIL rst_counters: got %h expected 0", {wr_beats, rd_beats}); end
    rst = 1'b0;
    #1;
    n_tests++; if ({bus.aw_ready, bus.ar_ready} !== 2'b11) begin n_fail++; $display("FAIL rel_ready: got %b expected 11", {bus.aw_ready, bus.ar_ready}); end
    tick();
  endtask

  task automatic test_incr();
    for (int i = 0; i < 4; i++) begin wdata[i] = 64'(i); wstrb[i] = 8'hFF; end
    send_aw(9'h01A, 32'h5000, 8'd3, 3'd3, INCR);
    send_w(4);
    get_b(0);
    n_tests++; if (bresp !== OKAY) begin n_fail++; $display("FAIL incr_bresp: got %b expected 00", bresp); end
    n_tests++; if (bid !== 9'h01A) begin n_fail++; $display("FAIL incr_bid: got %h expected 01a", bid); end
    send_ar(9'h105, 32'h5000, 8'd3, 3'd3, INCR);
    get_r(4);
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (rdata[i] !== 64'(i)) begin n_fail++; $display("FAIL incr_rdata%0d: got %h expected %h", i, rdata[i], 64'(i)); end
      n_tests++; if (rlast[i] !== (i == 3)) begin n_fail++; $display("FAIL incr_rlast%0d: got %b expected %b", i, rlast[i], (i == 3)); end
      n_tests++; if (rresp[i] !== OKAY) begin n_fail++; $display("FAIL incr_rresp%0d: got %b expected 00", i, rresp[i]); end
    end
    n_tests++; if (rid !== 9'h105) begin n_fail++; $display("FAIL incr_rid: got %h expected 105", rid); end
    n_tests++; if (wr_beats !== 32'd4) begin n_fail++; $display("FAIL incr_wr_beats: got %0d expected 4", wr_beats); end
    n_tests++; if (rd_beats !== 32'd4) begin n_fail++; $display("FAIL incr_rd_beats: got %0d expected 4", rd_beats); end
  endtask

  task automatic test_wrap();
    logic [63:0] exp [4] = '{64'd2, 64'd3, 64'd0, 64'd1};
    send_ar(9'h002, 32'h5010, 8'd3, 3'd3, WRAP);
    get_r(4);
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (rdata[i] !== exp[i]) begin n_fail++; $display("FAIL wrap_rdata%0d: got %h expected %h", i, rdata[i], exp[i]); end
      n_tests++; if (rresp[i] !== OKAY) begin n_fail++; $display("FAIL wrap_rresp%0d: got %b expected 00", i, rresp[i]); end
    end
  endtask

  task automatic test_strobe();
    wdata[0] = 64'h0; wstrb[0] = 8'hFF;
    send_aw(9'h003, 32'h5020, 8'd0, 3'd3, INCR);
    send_w(1);
    get_b(0);
    wdata[0] = 64'hFFFF_FFFF_FFFF_FFFF; wstrb[0] = 8'h0F;
    send_aw(9'h004, 32'h5020, 8'd0, 3'd3, INCR);
    send_w(1);
    get_b(0);
    n_tests++; if (bresp !== OKAY) begin n_fail++; $display("FAIL strb_bresp: got %b expected 00", bresp); end
    send_ar(9'h004, 32'h5020, 8'd0, 3'd3, INCR);
    get_r(1);
    n_tests++; if (rdata[0] !== 64'h0000_0000_FFFF_FFFF) begin n_fail++; $display("FAIL strb_rdata: got %h expected 00000000ffffffff", rdata[0]); end
  endtask

  task automatic test_boundary();
    wdata[0] = 64'hAAAA_AAAA_AAAA_AAAA; wstrb[0] = 8'hFF;
    wdata[1] = 64'hBBBB_BBBB_BBBB_BBBB; wstrb[1] = 8'hFF;
    send_aw(9'h005, 32'h6FF8, 8'd1, 3'd3, INCR);
    send_w(2);
    get_b(0);
    n_tests++; if (bresp !== SLVERR) begin n_fail++; $display("FAIL bnd_bresp: got %b expected 10", bresp); end
    send_ar(9'h006, 32'h6FF8, 8'd1, 3'd3, INCR);
    get_r(2);
    n_tests++; if (rdata[0] !== 64'hAAAA_AAAA_AAAA_AAAA) begin n_fail++; $display("FAIL bnd_rdata0: got %h expected aaaaaaaaaaaaaaaa", rdata[0]); end
    n_tests++; if (rresp[0] !== OKAY) begin n_fail++; $display("FAIL bnd_rresp0: got %b expected 00", rresp[0]); end
    n_tests++; if (rdata[1] !== 64'h0) begin n_fail++; $display("FAIL bnd_rdata1: got %h expected 0", rdata[1]); end
    n_tests++; if (rresp[1] !== SLVERR) begin n_fail++; $display("FAIL bnd_rresp1: got %b expected 10", rresp[1]); end
    n_tests++; if (rlast[1] !== 1'b1) begin n_fail++; $display("FAIL bnd_rlast1: got %b expected 1", rlast[1]); end
  endtask

  task automatic test_early_last_concurrent();
    wdata[0] = 64'h11; wstrb[0] = 8'hFF;
    wdata[1] = 64'h22; wstrb[1] = 8'hFF;
    bus.b_ready = 1'b0;
    send_aw(9'h007, 32'h5040, 8'd3, 3'd3, INCR);
    send_w(2);
    n_tests++; if (bus.b_valid !== 1'b1) begin n_fail++; $display("FAIL early_bvalid: got %b expected 1", bus.b_valid); end
    send_ar(9'h008, 32'h5000, 8'd1, 3'd3, INCR);
    get_r(2);
    n_tests++; if (rdata[0] !== 64'd0 || rdata[1] !== 64'd1) begin n_fail++; $display("FAIL conc_rdata: got %h %h expected 0 1", rdata[0], rdata[1]); end
    n_tests++; if (bus.b_valid !== 1'b1) begin n_fail++; $display("FAIL conc_bhold: got %b expected 1", bus.b_valid); end
    get_b(2);
    n_tests++; if (bresp !== SLVERR) begin n_fail++; $display("FAIL early_bresp: got %b expected 10", bresp); end
    n_tests++; if (bid !== 9'h007) begin n_fail++; $display("FAIL early_bid: got %h expected 007", bid); end
  endtask

  task automatic test_missing_last();
    wdata[0] = 64'h77; wstrb[0] = 8'hFF;
    wdata[1] = 64'h88; wstrb[1] = 8'hFF;
    send_aw(9'h009, 32'h5030, 8'd0, 3'd3, INCR);
    send_w(2);
    get_b(0);
    n_tests++; if (bresp !== SLVERR) begin n_fail++; $display("FAIL miss_bresp: got %b expected 10", bresp); end
    send_ar(9'h009, 32'h5030, 8'd0, 3'd3, INCR);
    get_r(1);
    n_tests++; if (rdata[0] !== 64'h77) begin n_fail++; $display("FAIL miss_rdata: got %h expected 77", rdata[0]); end
  endtask

  task automatic test_bad_wrap();
    send_ar(9'h00A, 32'h5000, 8'd2, 3'd3, WRAP);
    get_r(3);
    for (int i = 0; i < 3; i++) begin
      n_tests++; if (rresp[i] !== SLVERR || rdata[i] !== 64'h0) begin n_fail++; $display("FAIL badwrap%0d: got resp %b data %h expected 10 0", i, rresp[i], rdata[i]); end
    end
    n_tests++; if (rlast[2] !== 1'b1) begin n_fail++; $display("FAIL badwrap_last: got %b expected 1", rlast[2]); end
  endtask

  task automatic test_counters();
    n_tests++; if (wr_beats !== 32'd12) begin n_fail++; $display("FAIL cnt_wr: got %0d expected 12", wr_beats); end
    n_tests++; if (rd_beats !== 32'd17) begin n_fail++; $display("FAIL cnt_rd: got %0d expected 17", rd_beats); end
  endtask

  task automatic test_reset_mid_read();
    int hs = 0;
    send_ar(9'h00B, 32'h5000, 8'd7, 3'd3, INCR);
    bus.r_ready = 1'b1;
    for (int i = 0; i < 100 && hs < 2; i++) begin
      if (bus.r_valid) hs++;
      tick();
    end
    n_tests++; if (hs != 2) begin n_fail++; $display("FAIL midrd_beats: got %0d expected 2", hs); end
    rst = 1'b1;
    bus.r_ready = 1'b0;
    tick();
    n_tests++; if (bus.r_valid !== 1'b0) begin n_fail++; $display("FAIL midrd_rvalid: got %b expected 0", bus.r_valid); end
    n_tests++; if (bus.ar_ready !== 1'b0) begin n_fail++; $display("FAIL midrd_arready_rst: got %b expected 0", bus.ar_ready); end
    tick();
    rst = 1'b0;
    #1;
    n_tests++; if (bus.ar_ready !== 1'b1) begin n_fail++; $display("FAIL midrd_arready: got %b expected 1", bus.ar_ready); end
    n_tests++; if (rd_beats !== 32'd0) begin n_fail++; $display("FAIL midrd_cnt_rst: got %0d expected 0", rd_beats); end
    tick();
    send_ar(9'h00C, 32'h5000, 8'd3, 3'd3, INCR);
    get_r(4);
    for (int i = 0; i < 4; i++) begin
      n_tests++; if (rdata[i] !== 64'(i)) begin n_fail++; $display("FAIL midrd_rdata%0d: got %h expected %h", i, rdata[i], 64'(i)); end
    end
    n_tests++; if (rd_beats !== 32'd4) begin n_fail++; $display("FAIL midrd_cnt: got %0d expected 4", rd_beats); end
  endtask

  initial begin
    bus.aw_valid = 1'b0; bus.w_valid = 1'b0; bus.ar_valid = 1'b0;
    bus.b_ready  = 1'b0; bus.r_ready = 1'b0; bus.w_last  = 1'b0;
    bus.aw_id = '0; bus.aw_addr = '0; bus.aw_len = '0; bus.aw_size = '0; bus.aw_burst = '0; bus.aw_user = '0;
    bus.ar_id = '0; bus.ar_addr = '0; bus.ar_len = '0; bus.ar_size = '0; bus.ar_burst = '0; bus.ar_user = '0;
    bus.w_data = '0; bus.w_strb = '0; bus.w_user = '0;
    test_reset();
    test_incr();
    test_wrap();
    test_strobe();
    test_boundary();
    test_early_last_concurrent();
    test_missing_last();
    test_bad_wrap();
    test_counters();
    test_reset_mid_read();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
